// File: rtl/fruit_rom_arb_pkg.sv
// Shared types and helpers for the fruit template-ROM read arbiter.
package fruit_rom_arb_pkg;

    // Widest requester vector the helpers handle (NUM_REQ is limited to 2..8).
    localparam int MAX_REQ   = 8;
    localparam int PTR_MAX_W = 3;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Cyclic-priority pick: first set bit of valid, searching upward from ptr
    // and wrapping at num_req. Returns a one-hot (all zero when nothing valid).
    function automatic logic [MAX_REQ-1:0] rr_pick_onehot(
        input logic [MAX_REQ-1:0]   valid,
        input logic [PTR_MAX_W-1:0] ptr,
        input int                   num_req
    );
        logic [MAX_REQ-1:0]   grant;
        logic                 found;
        int                   idx;
        logic [PTR_MAX_W-1:0] idx_b;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx   = (int'(ptr) + k) % num_req;
            idx_b = PTR_MAX_W'(idx);
            if ((k < num_req) && !found && valid[idx_b]) begin
                grant[idx_b] = 1'b1;
                found        = 1'b1;
            end
        end
        return grant;
    endfunction

    // Index of the set bit in a one-hot vector (0 when the vector is empty).
    function automatic logic [PTR_MAX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [PTR_MAX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (oh[k]) begin
                idx = PTR_MAX_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fruit_rom_rr_pick.sv
// Combinational round-robin picker: one-hot grant from a valid vector and a
// rotating priority pointer.
module fruit_rom_rr_pick
    import fruit_rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic [MAX_REQ-1:0]   w_valid_wide;
    logic [PTR_MAX_W-1:0] w_ptr_wide;

    assign w_valid_wide = MAX_REQ'(i_valid);
    assign w_ptr_wide   = PTR_MAX_W'(i_rr_ptr);
    assign o_grant      = NUM_REQ'(rr_pick_onehot(w_valid_wide, w_ptr_wide, NUM_REQ));

endmodule

// File: rtl/fruit_rom_rd_arbiter.sv
// Round-robin read arbiter sharing one template ROM between NUM_REQ
// feature-matching engines, with burst lock and a one-hot tag pipe that
// routes each returned word back to the engine that issued it.
module fruit_rom_rd_arbiter
    import fruit_rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]            i_req_lock,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_lock_abort,
    output logic [ADDR_WIDTH-1:0]         o_rom_addr,
    output logic                          o_rom_clk_en,
    output logic                          o_rom_rd_oce,
    input  logic [DATA_WIDTH-1:0]         i_rom_rd_data
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LCNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_owner;
    logic [LCNT_W-1:0]   r_lock_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NUM_REQ-1:0]  r_tag [RD_LATENCY];

    logic [NUM_REQ-1:0]  w_pick;
    logic [NUM_REQ-1:0]  w_ready;
    logic [NUM_REQ-1:0]  w_owner_oh;
    logic                w_accept;
    logic [PTR_W-1:0]    w_acc_idx;
    logic                w_acc_lock;
    logic                w_release;
    logic                w_cnt_last;
    logic                w_timeout;
    logic                w_tag_any;

    // Next round-robin position after a given requester, wrapping at NUM_REQ.
    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    fruit_rom_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_valid  (i_req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_pick)
    );

    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    assign w_accept   = |w_ready;
    assign w_acc_idx  = PTR_W'(onehot_to_idx(MAX_REQ'(w_ready)));
    assign w_acc_lock = i_req_lock[w_acc_idx];
    assign w_release  = (r_state == ST_LOCK) && w_accept && !w_acc_lock;
    assign w_cnt_last = (MAX_LOCK != 0) && (r_lock_cnt == LCNT_W'(MAX_LOCK - 1));
    assign w_timeout  = (r_state == ST_LOCK) && w_cnt_last && !w_release;

    assign o_req_ready  = w_ready;
    assign o_lock_abort = w_timeout;
    assign o_rom_addr   = w_accept ? i_req_addr[int'(w_acc_idx)*ADDR_WIDTH +: ADDR_WIDTH] : r_addr;
    assign o_rom_clk_en = w_accept | w_tag_any;
    assign o_rom_rd_oce = 1'b1;
    assign o_rsp_valid  = r_tag[RD_LATENCY-1];
    assign o_rsp_data   = i_rom_rd_data;

    // State register for the arbitrate/lock FSM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Enter LOCK on a locked grant; leave on a release beat or timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_accept && w_acc_lock) begin
                    w_next_state = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (w_release || w_timeout) begin
                    w_next_state = ST_ARB;
                end
            end
            default: w_next_state = ST_ARB;
        endcase
    end

    // Ready strobe: round-robin pick in ARB, owner only in LOCK, silent in reset.
    always_comb begin
        w_ready = '0;
        if (!i_rst) begin
            case (r_state)
                ST_ARB:  w_ready = w_pick;
                ST_LOCK: w_ready = i_req_valid & w_owner_oh;
                default: w_ready = '0;
            endcase
        end
    end

    // Round-robin pointer, lock owner, lock timer and held ROM address.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_addr     <= '0;
        end else begin
            r_addr <= o_rom_addr;
            case (r_state)
                ST_ARB: begin
                    r_lock_cnt <= '0;
                    if (w_accept) begin
                        r_rr_ptr <= inc_ptr(w_acc_idx);
                        if (w_acc_lock) begin
                            r_owner <= w_acc_idx;
                        end
                    end
                end
                ST_LOCK: begin
                    r_lock_cnt <= r_lock_cnt + LCNT_W'(1);
                    if (w_release || w_timeout) begin
                        r_rr_ptr <= inc_ptr(r_owner);
                    end
                end
                default: r_lock_cnt <= '0;
            endcase
        end
    end

    // One-hot tag pipe matching the ROM read latency; reset drops in-flight reads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= w_ready;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Any read still in flight keeps the ROM clock enabled.
    always_comb begin
        w_tag_any = 1'b0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            w_tag_any = w_tag_any | (|r_tag[k]);
        end
    end

endmodule

// File: tb/tb_fruit_rom_rd_arbiter.sv
// Bench for fruit_rom_rd_arbiter: two instances (ROM latency 1 and 2) share
// one stimulus stream; a behavioural ROM feeds each, and per-instance queues
// hold the response each accepted beat must produce.
module tb_fruit_rom_rd_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;

    typedef struct {
        logic [NREQ-1:0] grant;
        logic [DW-1:0]   data;
        int              due;
    } rspExp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ*AW-1:0] reqAddr;
    logic [NREQ-1:0]   reqLock;

    logic [NREQ-1:0] ready1, rspValid1, ready2, rspValid2;
    logic [DW-1:0]   rspData1, rspData2, romData1, romData2, romStage2;
    logic            abort1, abort2, clkEn1, clkEn2, oce1, oce2;
    logic [AW-1:0]   romAddr1, romAddr2;

    int      cycle;
    int      compareCount;
    int      mismatchCount;
    rspExp_t q1[$];
    rspExp_t q2[$];
    logic [AW-1:0] lastAddr;

    fruit_rom_rd_arbiter #(
        .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .MAX_LOCK(16)
    ) dutLat1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .i_req_addr(reqAddr),
        .i_req_lock(reqLock), .o_req_ready(ready1), .o_rsp_valid(rspValid1),
        .o_rsp_data(rspData1), .o_lock_abort(abort1), .o_rom_addr(romAddr1),
        .o_rom_clk_en(clkEn1), .o_rom_rd_oce(oce1), .i_rom_rd_data(romData1)
    );

    fruit_rom_rd_arbiter #(
        .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .MAX_LOCK(16)
    ) dutLat2 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .i_req_addr(reqAddr),
        .i_req_lock(reqLock), .o_req_ready(ready2), .o_rsp_valid(rspValid2),
        .o_rsp_data(rspData2), .o_lock_abort(abort2), .o_rom_addr(romAddr2),
        .o_rom_clk_en(clkEn2), .o_rom_rd_oce(oce2), .i_rom_rd_data(romData2)
    );

    // ROM contents: a recognisable tag in the upper half, the address below.
    function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
        return 32'hA5A5_0000 | DW'(a);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Latency-1 ROM: output latched straight from the address.
    always @(posedge clk) begin
        if (clkEn1) romData1 <= romWord(romAddr1);
    end

    // Latency-2 ROM: array read stage followed by the output register.
    always @(posedge clk) begin
        if (clkEn2) begin
            romStage2 <= romWord(romAddr2);
            if (oce2) romData2 <= romStage2;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Response monitors: every cycle the returned one-hot must match the queue head when due, else be zero.
    always @(negedge clk) begin
        rspExp_t e;
        if (q1.size() > 0 && q1[0].due == cycle) begin
            e = q1.pop_front();
            checkOutput("rsp1_valid", 64'(rspValid1), 64'(e.grant));
            checkOutput("rsp1_data", 64'(rspData1), 64'(e.data));
        end else begin
            checkOutput("rsp1_idle", 64'(rspValid1), 64'd0);
        end
        if (q2.size() > 0 && q2[0].due == cycle) begin
            e = q2.pop_front();
            checkOutput("rsp2_valid", 64'(rspValid2), 64'(e.grant));
            checkOutput("rsp2_data", 64'(rspData2), 64'(e.data));
        end else begin
            checkOutput("rsp2_idle", 64'(rspValid2), 64'd0);
        end
    end

    // Drive one cycle of requests and check the grant, abort pulse and ROM address it must produce.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] lock,
                                 input logic [NREQ-1:0] expGrant, input logic expAbort,
                                 input string tag, input int addr0 = -1);
        rspExp_t e;
        logic [AW-1:0] a;
        int idx;
        @(posedge clk);
        #1;
        reqValid = valid;
        reqLock  = lock;
        for (int i = 0; i < NREQ; i++) reqAddr[i*AW +: AW] = AW'($urandom_range(0, 1023));
        if (addr0 >= 0) reqAddr[AW-1:0] = AW'(addr0);
        @(negedge clk);
        checkOutput({tag, "_ready1"}, 64'(ready1), 64'(expGrant));
        checkOutput({tag, "_ready2"}, 64'(ready2), 64'(expGrant));
        checkOutput({tag, "_abort1"}, 64'(abort1), 64'(expAbort));
        checkOutput({tag, "_abort2"}, 64'(abort2), 64'(expAbort));
        if (expGrant != '0) begin
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (expGrant[i]) idx = i;
            a = reqAddr[idx*AW +: AW];
            checkOutput({tag, "_addr1"}, 64'(romAddr1), 64'(a));
            checkOutput({tag, "_addr2"}, 64'(romAddr2), 64'(a));
            checkOutput({tag, "_clken1"}, 64'(clkEn1), 64'd1);
            e.grant = expGrant;
            e.data  = romWord(a);
            e.due   = cycle + 1;
            q1.push_back(e);
            e.due   = cycle + 2;
            q2.push_back(e);
            lastAddr = a;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready1"}, 64'(ready1), 64'd0);
        checkOutput({tag, "_ready2"}, 64'(ready2), 64'd0);
        checkOutput({tag, "_rsp1"}, 64'(rspValid1), 64'd0);
        checkOutput({tag, "_rsp2"}, 64'(rspValid2), 64'd0);
        checkOutput({tag, "_abort1"}, 64'(abort1), 64'd0);
        checkOutput({tag, "_addr1"}, 64'(romAddr1), 64'd0);
        checkOutput({tag, "_addr2"}, 64'(romAddr2), 64'd0);
        checkOutput({tag, "_clken1"}, 64'(clkEn1), 64'd0);
        checkOutput({tag, "_clken2"}, 64'(clkEn2), 64'd0);
        checkOutput({tag, "_oce2"}, 64'(oce2), 64'd1);
    endtask

    initial begin
        cycle = 0;
        compareCount = 0;
        mismatchCount = 0;
        lastAddr = '0;
        rst = 1'b1;
        reqValid = '0;
        reqLock = '0;
        reqAddr = '0;
        @(negedge clk);
        checkResetValues("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single requester, known ROM word");
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 1'b0, "single", 5);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, "single_gap");

        $display("[TB] all requesters valid, round-robin rotation");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 4'b0000, 4'(1 << ((1 + k) % NREQ)), 1'b0, "rotate");
        end

        $display("[TB] requester 2 eight-beat burst");
        applyStimulus(4'b0100, 4'b0100, 4'b0100, 1'b0, "burst_first");
        for (int k = 1; k < 7; k++) applyStimulus(4'b1111, 4'b0100, 4'b0100, 1'b0, "burst_mid");
        applyStimulus(4'b1111, 4'b0000, 4'b0100, 1'b0, "burst_last");
        applyStimulus(4'b1111, 4'b0000, 4'b1000, 1'b0, "after_burst");

        $display("[TB] lock timeout with owner gone idle");
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0, "to_lock");
        for (int k = 1; k < 16; k++) applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b0, "to_wait");
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1, "to_abort");
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b0, "to_next");

        $display("[TB] lock timeout with a beat in the abort cycle");
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b0, "tob_lock");
        for (int k = 1; k < 16; k++) applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b0, "tob_beat");
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b1, "tob_abort");
        applyStimulus(4'b1001, 4'b0000, 4'b0001, 1'b0, "tob_next");

        $display("[TB] idle: ROM gated, address held");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, "drain");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, "drain");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");
            checkOutput("idle_clken1", 64'(clkEn1), 64'd0);
            checkOutput("idle_clken2", 64'(clkEn2), 64'd0);
            checkOutput("idle_addr1", 64'(romAddr1), 64'(lastAddr));
            checkOutput("idle_addr2", 64'(romAddr2), 64'(lastAddr));
        end

        $display("[TB] reset with reads in flight");
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 1'b0, "pre_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        reqValid = 4'b1111;
        q1.delete();
        q2.delete();
        @(negedge clk);
        checkResetValues("mid_rst");
        @(negedge clk);
        checkResetValues("mid_rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        reqValid = '0;
        applyStimulus(4'b1111, 4'b0000, 4'b0001, 1'b0, "post_rst0");
        applyStimulus(4'b1111, 4'b0000, 4'b0010, 1'b0, "post_rst1");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, "tail");

        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("q1_drained", 64'(q1.size()), 64'd0);
        checkOutput("q2_drained", 64'(q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/fruit_rom_rd_arbiter.md
Name: fruit_rom_rd_arbiter

Overview:
- Shares one single-port template ROM (fruit reference-feature ROM, `ROM` mode SPRAM wrapper) between NUM_REQ feature-matching engines.
- Round-robin arbitration, one read issued per cycle.
- Optional burst lock lets an engine sweep a whole template contiguously.
- Tracks ROM read latency and routes each returned word to its issuer via a one-hot tag pipeline.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 10, ROM address width
- DATA_WIDTH, 32, ROM data width
- RD_LATENCY, 1, ROM read latency in cycles: 1 when the ROM has no output register, 2 when it does
- MAX_LOCK, 64, lock timeout in cycles; 0 disables the timeout

Ports:
- clk  in  1  single clock, shared with the ROM
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_lock  in  NUM_REQ  keep grant after this beat (burst continues)
- req_ready  out  NUM_REQ  one-hot accept strobe
- rsp_valid  out  NUM_REQ  one-hot read-data valid
- rsp_data  out  DATA_WIDTH  read data, broadcast to all requesters
- lock_abort  out  1  one-cycle pulse when a lock is forcibly released
- rom_addr  out  ADDR_WIDTH  to ROM addr
- rom_clk_en  out  1  to ROM clk_en
- rom_rd_oce  out  1  to ROM rd_oce
- rom_rd_data  in  DATA_WIDTH  from ROM rd_data

Behaviour:
- Reset values:
  - Outputs: req_ready=0, rsp_valid=0, lock_abort=0, rom_addr=0, rom_clk_en=0, rom_rd_oce=1.
  - Internal: rr_ptr=0, state=ARB, lock_cnt=0, tag pipe cleared.
- Accept rule: beat accepted for i when req_valid[i] & req_ready[i] in the same cycle. req_ready is combinational from req_valid and state. At most one bit is set.
- ARB state:
  - Grant the first i with req_valid[i], searching cyclically from rr_ptr.
  - On accept, rr_ptr <= (i+1) mod NUM_REQ.
  - If req_lock[i]=1 on that beat: go to LOCK, owner <= i, lock_cnt <= 0.
- LOCK state:
  - req_ready[owner] = req_valid[owner]; all other ready bits are 0.
  - lock_cnt increments every cycle, including idle ones.
  - Leave to ARB when the owner accepts a beat with req_lock=0. rr_ptr <= owner+1.
  - Timeout: if MAX_LOCK != 0 and lock_cnt == MAX_LOCK-1 with no release beat, go to ARB, pulse lock_abort for 1 cycle, rr_ptr <= owner+1. A beat accepted in that same cycle is still served.
- Address path:
  - rom_addr = req_addr of the accepted requester, combinational.
  - If no accept, rom_addr holds its last registered value, so the port needs an internal register.
- Tag pipe:
  - RD_LATENCY stages of NUM_REQ-bit one-hot; stage0 <= accepted one-hot (0 if none).
  - rsp_valid = last stage. rsp_data = rom_rd_data, passed through combinationally.
  - A beat accepted in cycle T produces rsp_valid in cycle T+RD_LATENCY.
- rom_clk_en = accept OR any tag-pipe bit set, so the ROM is gated off when idle.
- rom_rd_oce is tied 1.
- Throughput is 1 beat/cycle. Back-to-back beats from different requesters are legal; responses return in issue order.
- Single requester with NUM_REQ-1 idle: granted every cycle it is valid.
- Reset mid-operation: the tag pipe is flushed, in-flight responses are dropped (no rsp_valid after rst), and a held lock is released without a lock_abort pulse.
- req_lock on a non-granted requester is ignored.

Decomposition:
- Package fruit_rom_arb_pkg holds:
  - State encoding ST_ARB/ST_LOCK.
  - Function for cyclic-priority pick returning a one-hot.
  - Function for one-hot to index.
- Sub-module fruit_rom_rr_pick: combinational round-robin picker, inputs valid vector + rr_ptr, output one-hot grant.
- The tag pipe and lock FSM stay in the top.

Test Plan:
- Reset, then req_valid=4'b0001, addr0=5, ROM word[5]=0xA5A5_0005, RD_LATENCY=1 -> req_ready=0001 in cycle T, rsp_valid=0001 with rsp_data=0xA5A5_0005 in T+1.
- All four valid continuously, no lock -> grant sequence 0,1,2,3,0,…; rsp_valid follows exactly RD_LATENCY cycles later; repeat with RD_LATENCY=2.
- Requester 2 bursts 8 beats (req_lock=1 on beats 0..6, 0 on beat 7) while 0, 1, 3 are valid -> only 2 granted for 8 beats, then grant goes to 3 and rr_ptr=3.
- MAX_LOCK=16, requester 1 locks then drops req_valid -> lock_abort pulses 16 cycles after the lock beat; the next grant goes to requester 2 (if valid).
- rst asserted one cycle after an accept with RD_LATENCY=2 -> no rsp_valid appears; all outputs are at reset values while rst=1.
- Idle 10 cycles after the last response -> rom_clk_en=0 throughout and rom_addr holds its previous value.
